// File: rtl/param_counter_pkg.sv
// Shared types and default parameters for the parameterised up/down counter.
package param_counter_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_MOD     = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

endpackage

// File: rtl/sync_edge.sv
// Synchronizer with rising-edge detect. Edges are only reported once the
// synced level has been seen low after reset, so an input already high at
// reset release needs a fresh low-to-high transition.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] fill_q;   // marks when chain_q holds post-reset samples
    logic                   prev_q;
    logic                   armed_q;

    // Synchronizer chain, edge history and arming after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_in};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= chain_q[SYNC_STAGES-1];
            if (fill_q[SYNC_STAGES-1] && !chain_q[SYNC_STAGES-1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign level = chain_q[SYNC_STAGES-1];
    assign rise  = armed_q & chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/param_counter.sv
// Up/down counter driven by asynchronous strobes, with wrap, saturate,
// modulo and one-shot modes, terminal-count pulse and sticky done flag.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clk_in,
    input  logic             load,
    input  logic             up_down,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam int unsigned BusW  = 2 * WIDTH + 3;
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MaxV = {WIDTH{1'b1}};

    logic en_level, en_rise_unused;
    logic step_rise, step_level_unused;
    logic load_rise, load_level_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_enable (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (enable),
        .level    (en_level),
        .rise     (en_rise_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk_in (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (clk_in),
        .level    (step_level_unused),
        .rise     (step_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (load),
        .level    (load_level_unused),
        .rise     (load_rise)
    );

    // Level inputs share one chain of the same depth as load, keeping in aligned with it.
    logic [SYNC_STAGES-1:0][BusW-1:0] bus_q;

    // Plain synchronizer chain for in, limit, up_down and mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_q <= '0;
        end else begin
            bus_q <= {bus_q[SYNC_STAGES-2:0], {in, limit, up_down, mode}};
        end
    end

    logic [WIDTH-1:0] in_s, limit_s;
    logic             up_s;
    mode_e            mode_s;

    assign in_s    = bus_q[SYNC_STAGES-1][BusW-1 -: WIDTH];
    assign limit_s = bus_q[SYNC_STAGES-1][WIDTH+2 -: WIDTH];
    assign up_s    = bus_q[SYNC_STAGES-1][2];
    assign mode_s  = mode_e'(bus_q[SYNC_STAGES-1][1:0]);

    logic [WIDTH-1:0] count_q, count_d, step_val, term;
    logic             tc_q, tc_d, done_q, done_d;
    logic             oneshot_hold;

    // Next-count computation for one step, then load/step arbitration.
    always_comb begin
        count_d  = count_q;
        done_d   = done_q;
        tc_d     = 1'b0;
        step_val = count_q;
        term     = '0;

        unique case (mode_s)
            MODE_WRAP: begin
                step_val = up_s ? count_q + One : count_q - One;
                term     = up_s ? MaxV : '0;
            end
            MODE_SAT: begin
                if (up_s) step_val = (count_q == MaxV) ? MaxV : count_q + One;
                else      step_val = (count_q == '0)   ? '0   : count_q - One;
                term = up_s ? MaxV : '0;
            end
            MODE_MOD, MODE_ONESHOT: begin
                if (up_s) begin
                    if (count_q >= limit_s) begin
                        step_val = (mode_s == MODE_MOD) ? '0 : limit_s;
                    end else begin
                        step_val = count_q + One;
                    end
                end else if (limit_s == '0) begin
                    step_val = '0;
                end else if (count_q == '0) begin
                    step_val = (mode_s == MODE_MOD) ? limit_s : '0;
                end else if (count_q > limit_s) begin
                    step_val = limit_s;
                end else begin
                    step_val = count_q - One;
                end
                term = up_s ? limit_s : '0;
            end
            default: ;
        endcase

        oneshot_hold = (mode_s == MODE_ONESHOT) && done_q;

        if (en_level && load_rise) begin
            count_d = in_s;
            done_d  = 1'b0;
        end else if (en_level && step_rise && !oneshot_hold) begin
            count_d = step_val;
            tc_d    = (step_val != count_q) && (step_val == term);
            if (mode_s == MODE_ONESHOT && step_val == term) begin
                done_d = 1'b1;
            end
        end
    end

    // Output state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter: WIDTH, default 8, counter and data width (2..32).
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth per asynchronous input (2..4).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 enable  input  1  asynchronous count/load enable.
REQ-007 clk_in  input  1  asynchronous count strobe; each rising edge is one step.
REQ-008 load  input  1  asynchronous load strobe; each rising edge loads in.
REQ-009 up_down  input  1  asynchronous direction: 1 up, 0 down.
REQ-010 mode  input  2  asynchronous mode: 00 wrap, 01 saturate, 10 modulo, 11 one-shot.
REQ-011 in  input  WIDTH  asynchronous load value; held stable >= SYNC_STAGES+2 clk cycles around the load edge.
REQ-012 limit  input  WIDTH  asynchronous modulus/terminal value for modes 10/11; quasi-static.
REQ-013 count  output  WIDTH  current count, registered.
REQ-014 tc  output  1  terminal-count pulse, registered, one clk wide.
REQ-015 done  output  1  one-shot completion flag, registered, sticky.

Function
REQ-016 Every asynchronous input SHALL pass through SYNC_STAGES flops before use; in and limit SHALL use the same depth as load, so in is sampled aligned with the load edge.
REQ-017 Rising edges of clk_in and load SHALL be detected as synced=1 and previous-synced=0; edges occurring while synced enable=0 are discarded, not queued.
REQ-018 Latency: a clk_in or load edge first captured at clk edge N SHALL update count at clk edge N+SYNC_STAGES.
REQ-019 Load edge with enable=1: count <= synced in, done <= 0, tc unaffected; load wins over a simultaneous step.
REQ-020 Wrap mode: up from 2^WIDTH-1 -> 0, down from 0 -> 2^WIDTH-1.
REQ-021 Saturate mode: up holds at 2^WIDTH-1, down holds at 0.
REQ-022 Modulo mode: up from count>=limit -> 0; down from 0 -> limit; down from count>limit -> limit; limit=0 holds count at 0.
REQ-023 One-shot mode: steps as modulo without wrap; when count reaches terminal (limit up, 0 down) done <= 1; while done=1 steps are ignored.
REQ-024 tc SHALL pulse high one cycle, coincident with the count update, whenever a step changes count to its terminal value (up: 2^WIDTH-1 in modes 00/01, limit in 10/11; down: 0); no pulse when count is unchanged.
REQ-025 mode, up_down, limit changes SHALL take effect at the next step; no retroactive correction of count.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH with explicit bound checks; no carry out is exposed.

Reset
REQ-027 With rst_n=0 at a clk edge: count=0, tc=0, done=0, all synchronizer and edge-detect flops=0.
REQ-028 Reset mid-operation SHALL abort pending edges; after release, an input already high SHALL NOT produce an edge until it goes low then high.

Structure
REQ-029 Package param_counter_pkg SHALL hold the mode enum (MODE_WRAP, MODE_SAT, MODE_MOD, MODE_ONESHOT) and the default-parameter constants.
REQ-030 Sub-module sync_edge (parameter SYNC_STAGES, outputs synced level and rise pulse) SHALL be instantiated for enable, clk_in, load; in/limit/up_down/mode use plain synchronizer chains.

Verification
REQ-031 WIDTH=8, wrap, up, load 8'hFE, 3 clk_in edges -> count FF (tc pulse), 00, 01.
REQ-032 Saturate, down, load 8'h01, 3 edges -> 00 (one tc pulse), 00, 00; no further tc.
REQ-033 Modulo limit=5, up from 0, 7 edges -> 1,2,3,4,5(tc),0,1; then down from 0 -> 5.
REQ-034 One-shot limit=3, up from 0, 5 edges -> 1,2,3 (tc, done=1), 3, 3; load 0 -> done=0.
REQ-035 Load and clk_in edges in same cycle, in=8'h40 -> count 40 exactly SYNC_STAGES cycles after capture; enable=0 edges -> count unchanged.
REQ-036 rst_n low mid-sequence with clk_in held high -> count=0, done=0; no step until next clk_in low-high.
